// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter for IF and DM requesters: issue, fixed-latency wait, response.
// Define MEM_ARB_ROUND_ROBIN_EN to replace DM-priority/FAIR_LIMIT arbitration with round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifGnt,
  output logic              ifValid,
  output logic [DATA_W-1:0] ifData,
  input  logic              dmReq,
  input  logic              dmWrite,
  input  logic [ADDR_W-1:0] dmAddr,
  input  logic [DATA_W-1:0] dmWData,
  output logic              dmGnt,
  output logic              dmValid,
  output logic [DATA_W-1:0] dmData,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  output logic              stallIF,
  output logic              stallMEM
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  logic               r_owner_dm;
  logic               r_is_write;
  logic [CNT_W-1:0]   r_cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic               r_last_dm;
`else
  localparam int STK_W = $clog2(FAIR_LIMIT + 1);
  logic [STK_W-1:0]   r_streak;
`endif

  logic w_pick_dm;
  logic w_rd_busy;

  always_comb begin
    // NOTE: assigning a default before any condition keeps this purely combinational (no latch).
    w_pick_dm = dmReq;
    if (ifReq && dmReq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w_pick_dm = ~r_last_dm;
`else
      w_pick_dm = (r_streak != STK_W'(FAIR_LIMIT));
`endif
    end
  end

  // A read is in flight from its issue cycle up to and including its response cycle.
  assign w_rd_busy = (r_state != S_IDLE) && !r_is_write;

  assign stallIF  = rst_n & (ifReq | (w_rd_busy & ~r_owner_dm)) & ~ifValid;
  assign stallMEM = rst_n & ((dmReq & ~(dmGnt & dmWrite)) |
                             (w_rd_busy & r_owner_dm & ~dmValid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner_dm <= 1'b0;
      r_is_write <= 1'b0;
      r_cnt      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_dm  <= 1'b0;
`else
      r_streak   <= '0;
`endif
      ifGnt      <= 1'b0;
      dmGnt      <= 1'b0;
      ifValid    <= 1'b0;
      dmValid    <= 1'b0;
      ifData     <= '0;
      dmData     <= '0;
      memEn      <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWData   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      ifGnt   <= 1'b0;
      dmGnt   <= 1'b0;
      memEn   <= 1'b0;
      memWe   <= 1'b0;
      ifValid <= 1'b0;
      dmValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifndef MEM_ARB_ROUND_ROBIN_EN
          if (!ifReq || !w_pick_dm) r_streak <= '0;
          else                      r_streak <= r_streak + STK_W'(1);
`endif
          if (ifReq || dmReq) begin
            r_owner_dm <= w_pick_dm;
            r_is_write <= w_pick_dm & dmWrite;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_dm  <= w_pick_dm;
`endif
            memEn      <= 1'b1;
            memWe      <= w_pick_dm & dmWrite;
            memAddr    <= w_pick_dm ? dmAddr : ifAddr;
            memWData   <= w_pick_dm ? dmWData : '0;
            dmGnt      <= w_pick_dm;
            ifGnt      <= ~w_pick_dm;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_is_write) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_owner_dm) begin
              dmData  <= memRData;
              dmValid <= 1'b1;
            end else begin
              ifData  <= memRData;
              ifValid <= 1'b1;
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timeline reference model checked every cycle plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int FL  = 4;
  localparam int NC  = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifReq, dmReq, dmWrite;
  logic [31:0] ifAddr, dmAddr, memAddr;
  logic [15:0] dmWData, memRData, ifData, dmData, memWData;
  logic        ifGnt, ifValid, dmGnt, dmValid, memEn, memWe, stallIF, stallMEM;

  logic        l1_dmReq, l1_dmWrite;
  logic [31:0] l1_dmAddr, l1_memAddr;
  logic [15:0] l1_dmWData, l1_memRData, l1_ifData, l1_dmData, l1_memWData;
  logic        l1_ifGnt, l1_ifValid, l1_dmGnt, l1_dmValid, l1_memEn, l1_memWe;
  logic        l1_stallIF, l1_stallMEM;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference timeline: expected per-cycle events, filled when the model arbitrates.
  logic        e_ifgnt[NC], e_dmgnt[NC], e_en[NC], e_we[NC];
  logic        e_ifv[NC], e_dmv[NC], e_if_fl[NC], e_dm_fl[NC];
  logic [31:0] e_addr[NC];
  logic [15:0] e_wd[NC], e_rd[NC];
  int          m_idle_from = 0;
  int          m_streak = 0;
  bit          m_last_dm = 1'b0;
  logic [15:0] m_if_data = '0, m_dm_data = '0;

  int  if_left = 0, dm_left = 0, dm_wmode = 0;
  bit  rnd_mode = 1'b0;
  int  mem_due = -1;
  logic [31:0] mem_ra = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(16), .MEM_LAT(LAT), .FAIR_LIMIT(FL)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifValid(ifValid), .ifData(ifData),
    .dmReq(dmReq), .dmWrite(dmWrite), .dmAddr(dmAddr), .dmWData(dmWData),
    .dmGnt(dmGnt), .dmValid(dmValid), .dmData(dmData),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .stallIF(stallIF), .stallMEM(stallMEM)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(16), .MEM_LAT(1), .FAIR_LIMIT(FL)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .ifReq(1'b0), .ifAddr(32'h0), .ifGnt(l1_ifGnt), .ifValid(l1_ifValid), .ifData(l1_ifData),
    .dmReq(l1_dmReq), .dmWrite(l1_dmWrite), .dmAddr(l1_dmAddr), .dmWData(l1_dmWData),
    .dmGnt(l1_dmGnt), .dmValid(l1_dmValid), .dmData(l1_dmData),
    .memEn(l1_memEn), .memWe(l1_memWe), .memAddr(l1_memAddr), .memWData(l1_memWData),
    .memRData(l1_memRData), .stallIF(l1_stallIF), .stallMEM(l1_stallMEM)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hash(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'hBEAF;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Memory model: read data is correct only in the cycle MEM_LAT after the issue cycle.
  always @(negedge clk) begin
    if (rst_n && memEn && !memWe) begin
      mem_due = cyc + LAT;
      mem_ra  = memAddr;
    end
  end
  always begin
    @(posedge clk);
    #1;
    memRData = (cyc == mem_due) ? hash(mem_ra) : 16'($urandom);
  end

  // Per-cycle monitor against the reference timeline.
  always @(negedge clk) begin : mon
    int c, g, v;
    bit both, pick;
    logic [7:0] exp_ctl, got_ctl;
    c = cyc;
    got_ctl = {ifGnt, dmGnt, memEn, memWe, ifValid, dmValid, stallIF, stallMEM};
    if (!rst_n) begin
      checks++;
      if ({got_ctl, memAddr, memWData, ifData, dmData} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d ctl=%b addr=%h wd=%h ifd=%h dmd=%h exp all zero",
                 c, got_ctl, memAddr, memWData, ifData, dmData);
      end
      for (int k = c; k < c + LAT + 6 && k < NC; k++) begin
        e_ifgnt[k] = 0; e_dmgnt[k] = 0; e_en[k] = 0; e_we[k] = 0;
        e_ifv[k] = 0; e_dmv[k] = 0; e_if_fl[k] = 0; e_dm_fl[k] = 0;
      end
      m_idle_from = c + 1;
      m_streak = 0;
      m_last_dm = 1'b0;
      m_if_data = '0;
      m_dm_data = '0;
    end else begin
      if (e_ifv[c]) m_if_data = e_rd[c];
      if (e_dmv[c]) m_dm_data = e_rd[c];
      exp_ctl = {e_ifgnt[c], e_dmgnt[c], e_en[c], e_we[c], e_ifv[c], e_dmv[c],
                 (ifReq | e_if_fl[c]) & ~e_ifv[c],
                 (dmReq & ~(e_dmgnt[c] & dmWrite)) | (e_dm_fl[c] & ~e_dmv[c])};
      checks++;
      if (got_ctl !== exp_ctl) begin
        failures++;
        $display("FAIL ctl{ifGnt,dmGnt,memEn,memWe,ifValid,dmValid,stallIF,stallMEM} cyc=%0d got=%b exp=%b",
                 c, got_ctl, exp_ctl);
      end
      if (e_en[c]) begin
        checks++;
        if (memAddr !== e_addr[c]) begin
          failures++;
          $display("FAIL memAddr cyc=%0d got=%h exp=%h", c, memAddr, e_addr[c]);
        end
      end
      if (e_we[c]) begin
        checks++;
        if (memWData !== e_wd[c]) begin
          failures++;
          $display("FAIL memWData cyc=%0d got=%h exp=%h", c, memWData, e_wd[c]);
        end
      end
      checks++;
      if ({ifData, dmData} !== {m_if_data, m_dm_data}) begin
        failures++;
        $display("FAIL rdata cyc=%0d ifData=%h dmData=%h exp %h %h", c, ifData, dmData, m_if_data, m_dm_data);
      end
      if (c >= m_idle_from) begin
        if (ifReq || dmReq) begin
          both = ifReq && dmReq;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          pick = both ? !m_last_dm : dmReq;
          m_last_dm = pick;
`else
          pick = both ? (m_streak < FL) : dmReq;
          m_streak = (ifReq && pick) ? m_streak + 1 : 0;
`endif
          g = c + 1;
          e_en[g] = 1'b1;
          e_we[g] = pick && dmWrite;
          e_addr[g] = pick ? dmAddr : ifAddr;
          e_wd[g] = dmWData;
          if (pick) e_dmgnt[g] = 1'b1; else e_ifgnt[g] = 1'b1;
          if (pick && dmWrite) begin
            m_idle_from = c + 2;
          end else begin
            v = c + LAT + 2;
            e_rd[v] = hash(e_addr[g]);
            if (pick) e_dmv[v] = 1'b1; else e_ifv[v] = 1'b1;
            for (int k = g; k <= v; k++) begin
              if (pick) e_dm_fl[k] = 1'b1; else e_if_fl[k] = 1'b1;
            end
            m_idle_from = v + 1;
          end
        end else begin
          m_streak = 0;
        end
      end
    end
  end

  // One clock of requester behaviour: finish an access when the model says it was granted.
  task automatic step();
    @(posedge clk);
    #1;
    if (ifReq && e_ifgnt[cyc-1]) begin
      if (if_left > 1) begin
        if_left--;
        ifAddr = $urandom;
      end else begin
        if_left = 0;
        ifReq = 1'b0;
      end
    end
    if (dmReq && e_dmgnt[cyc-1]) begin
      if (dm_left > 1) begin
        dm_left--;
        dmAddr = $urandom;
        dmWData = 16'($urandom);
        dmWrite = (dm_wmode == 2) ? 1'($urandom % 2) : dm_wmode[0];
      end else begin
        dm_left = 0;
        dmReq = 1'b0;
      end
    end
    if (rnd_mode) begin
      if (!ifReq && ($urandom % 4 == 0)) begin
        ifReq = 1'b1; if_left = 1 + $urandom % 3; ifAddr = $urandom;
      end
      if (!dmReq && ($urandom % 3 == 0)) begin
        dmReq = 1'b1; dm_left = 1 + $urandom % 4; dmAddr = $urandom;
        dmWData = 16'($urandom); dmWrite = 1'($urandom % 2);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    ifReq = 1'b1; dmReq = 1'b1; dmWrite = 1'b0;
    repeat (3) step();
    checks++;
    if ({stallIF, stallMEM} !== 2'b00) begin
      failures++;
      $display("FAIL reset_stall_forced got=%b exp=00", {stallIF, stallMEM});
    end
    ifReq = 1'b0; dmReq = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic record(inout int ord[$], inout int gc[$]);
    if (ifGnt) begin ord.push_back(0); gc.push_back(cyc); end
    if (dmGnt) begin ord.push_back(1); gc.push_back(cyc); end
  endtask

  task automatic test_both_reading();
    int ord[$], gc[$];
    int exp_ord[6];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_ord = '{1, 0, 1, 0, 1, 0};
`else
    exp_ord = '{1, 1, 1, 0, 0, 0};
`endif
    dm_wmode = 0;
    ifReq = 1'b1; if_left = 3; ifAddr = $urandom;
    dmReq = 1'b1; dm_left = 3; dmAddr = $urandom; dmWrite = 1'b0;
    for (int i = 0; i < 60 && ord.size() < 6; i++) begin
      step();
      record(ord, gc);
    end
    checks++;
    if (ord.size() != 6) begin
      failures++;
      $display("FAIL both_read_grant_count got=%0d exp=6", ord.size());
    end
    for (int i = 0; i < 6 && i < ord.size(); i++) begin
      checks++;
      if (ord[i] != exp_ord[i]) begin
        failures++;
        $display("FAIL both_read_order idx=%0d got_dm=%0d exp_dm=%0d", i, ord[i], exp_ord[i]);
      end
    end
    repeat (8) step();
  endtask

  task automatic test_if_read();
    int n;
    step();
    ifReq = 1'b1; ifAddr = 32'h40; if_left = 1;
    n = cyc;
    step();
    checks++;
    if ({ifGnt, memEn, memWe, memAddr} !== {1'b1, 1'b1, 1'b0, 32'h40}) begin
      failures++;
      $display("FAIL if_read_issue got gnt=%b en=%b we=%b addr=%h exp 1 1 0 00000040",
               ifGnt, memEn, memWe, memAddr);
    end
    while (cyc < n + 3) step();
    checks++;
    if ({stallIF, ifValid} !== 2'b10) begin
      failures++;
      $display("FAIL if_read_wait got stallIF=%b ifValid=%b exp 1 0", stallIF, ifValid);
    end
    step();
    checks++;
    if ({ifValid, ifData, stallIF} !== {1'b1, 16'hBEEF, 1'b0}) begin
      failures++;
      $display("FAIL if_read_resp got valid=%b data=%h stall=%b exp 1 beef 0", ifValid, ifData, stallIF);
    end
    repeat (3) step();
  endtask

  task automatic test_dm_write();
    dm_wmode = 1;
    dmReq = 1'b1; dmWrite = 1'b1; dmAddr = 32'h100; dmWData = 16'h1234; dm_left = 1;
    step();
    checks++;
    if ({dmGnt, memEn, memWe, memAddr, memWData, stallMEM} !== {1'b1, 1'b1, 1'b1, 32'h100, 16'h1234, 1'b0}) begin
      failures++;
      $display("FAIL dm_write_issue got gnt=%b en=%b we=%b addr=%h wd=%h stall=%b exp 1 1 1 00000100 1234 0",
               dmGnt, memEn, memWe, memAddr, memWData, stallMEM);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (dmValid !== 1'b0) begin
        failures++;
        $display("FAIL dm_write_no_valid cyc=%0d got=%b exp=0", cyc, dmValid);
      end
    end
  endtask

  task automatic test_contention();
    int ord[$], gc[$];
    int exp_ord[6], exp_gap[5];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_ord = '{0, 1, 1, 1, 1, 1};
    exp_gap = '{LAT + 3, 2, 2, 2, 2};
`else
    exp_ord = '{1, 1, 1, 1, 0, 1};
    exp_gap = '{2, 2, 2, 2, LAT + 3};
`endif
    dm_wmode = 1;
    ifReq = 1'b1; ifAddr = 32'h200; if_left = 1;
    dmReq = 1'b1; dmWrite = 1'b1; dmAddr = $urandom; dmWData = 16'($urandom); dm_left = 5;
    for (int i = 0; i < 80 && ord.size() < 6; i++) begin
      step();
      record(ord, gc);
    end
    checks++;
    if (ord.size() != 6) begin
      failures++;
      $display("FAIL contention_grant_count got=%0d exp=6", ord.size());
    end
    for (int i = 0; i < 6 && i < ord.size(); i++) begin
      checks++;
      if (ord[i] != exp_ord[i]) begin
        failures++;
        $display("FAIL contention_order idx=%0d got_dm=%0d exp_dm=%0d", i, ord[i], exp_ord[i]);
      end
      if (i > 0) begin
        checks++;
        if (gc[i] - gc[i-1] != exp_gap[i-1]) begin
          failures++;
          $display("FAIL contention_gap idx=%0d got=%0d exp=%0d", i, gc[i] - gc[i-1], exp_gap[i-1]);
        end
      end
    end
    repeat (8) step();
  endtask

  task automatic test_reset_mid_read();
    int n;
    ifReq = 1'b1; ifAddr = 32'h80; if_left = 1;
    n = cyc;
    while (cyc < n + 2) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifGnt, dmGnt, memEn, memWe, ifValid, dmValid, stallIF, stallMEM,
         memAddr, memWData, ifData, dmData} !== '0) begin
      failures++;
      $display("FAIL reset_mid_read_async got ctl=%b addr=%h ifd=%h dmd=%h exp all zero",
               {ifGnt, dmGnt, memEn, memWe, ifValid, dmValid, stallIF, stallMEM}, memAddr, ifData, dmData);
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (ifValid !== 1'b0) begin
        failures++;
        $display("FAIL reset_dropped_valid cyc=%0d got=%b exp=0", cyc, ifValid);
      end
    end
    ifReq = 1'b1; ifAddr = 32'h90; if_left = 1;
    n = cyc;
    while (cyc < n + LAT + 1) step();
    checks++;
    if (ifValid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_early_valid got=%b exp=0", ifValid);
    end
    step();
    checks++;
    if ({ifValid, ifData} !== {1'b1, hash(32'h90)}) begin
      failures++;
      $display("FAIL post_reset_read got valid=%b data=%h exp 1 %h", ifValid, ifData, hash(32'h90));
    end
    repeat (3) step();
  endtask

  task automatic test_lat1();
    l1_dmReq = 1'b1; l1_dmWrite = 1'b0; l1_dmAddr = 32'h300;
    step();
    checks++;
    if ({l1_dmGnt, l1_memEn, l1_memWe} !== 3'b110) begin
      failures++;
      $display("FAIL lat1_issue got gnt=%b en=%b we=%b exp 1 1 0", l1_dmGnt, l1_memEn, l1_memWe);
    end
    step();
    l1_dmReq = 1'b0;
    l1_memRData = 16'h00FF;
    checks++;
    if (l1_dmValid !== 1'b0) begin
      failures++;
      $display("FAIL lat1_early_valid got=%b exp=0", l1_dmValid);
    end
    step();
    l1_memRData = 16'h1111;
    checks++;
    if ({l1_dmValid, l1_dmData} !== {1'b1, 16'h00FF}) begin
      failures++;
      $display("FAIL lat1_resp got valid=%b data=%h exp 1 00ff", l1_dmValid, l1_dmData);
    end
    repeat (2) step();
  endtask

  task automatic test_random();
    dm_wmode = 2;
    rnd_mode = 1'b1;
    repeat (1500) step();
    rnd_mode = 1'b0;
    repeat (80) step();
    checks++;
    if ({stallIF, stallMEM} !== 2'b00) begin
      failures++;
      $display("FAIL random_drain_stalls got=%b exp=00", {stallIF, stallMEM});
    end
  endtask

  initial begin
    for (int k = 0; k < NC; k++) begin
      e_ifgnt[k] = 0; e_dmgnt[k] = 0; e_en[k] = 0; e_we[k] = 0;
      e_ifv[k] = 0; e_dmv[k] = 0; e_if_fl[k] = 0; e_dm_fl[k] = 0;
      e_addr[k] = '0; e_wd[k] = '0; e_rd[k] = '0;
    end
    ifReq = 1'b0; dmReq = 1'b0; dmWrite = 1'b0;
    ifAddr = '0; dmAddr = '0; dmWData = '0; memRData = '0;
    l1_dmReq = 1'b0; l1_dmWrite = 1'b0; l1_dmAddr = '0; l1_dmWData = '0; l1_memRData = 16'h1111;
    test_reset();
    test_both_reading();
    test_if_read();
    test_dm_write();
    test_contention();
    test_reset_mid_read();
    test_lat1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
